// File: rtl/m2_fsl_chan_mux.sv
// Multi-channel FSL mux/demux between the user FSL endpoints and the single tagged link word stream.
// TX: round-robin arbitration with optional packet lock; RX: tag-steered delivery, invalid tags dropped.
module m2_fsl_chan_mux #(
    parameter int C_NUM_CH   = 4,
    parameter int C_DWIDTH   = 64,
    parameter int C_CH_W     = 2,
    parameter int C_PKT_MODE = 1
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [0:C_NUM_CH*C_DWIDTH-1]     i_sfsl_data,
    input  logic [0:C_NUM_CH-1]              i_sfsl_control,
    input  logic [0:C_NUM_CH-1]              i_sfsl_exists,
    output logic [0:C_NUM_CH-1]              o_sfsl_read,
    output logic                             o_tx_valid,
    output logic [0:C_CH_W+C_DWIDTH]         o_tx_data,
    input  logic                             i_tx_ready,
    input  logic                             i_rx_valid,
    input  logic [0:C_CH_W+C_DWIDTH]         i_rx_data,
    output logic                             o_rx_ready,
    output logic [0:C_NUM_CH-1]              o_mfsl_write,
    output logic [0:C_DWIDTH-1]              o_mfsl_data,
    output logic                             o_mfsl_control,
    input  logic [0:C_NUM_CH-1]              i_mfsl_full,
    output logic [0:31]                      o_dbg_tx_cnt,
    output logic [0:31]                      o_dbg_rx_cnt,
    output logic [0:15]                      o_dbg_rx_err
);
    localparam int LW = C_CH_W + 1 + C_DWIDTH;

    // Handshakes: a link word moves when valid & ready are both high in the same cycle; an FSL
    // read/write strobe is a one-cycle pop/push that is only raised when exists=1 / full=0.
    typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

    state_t              r_state, w_state_nxt;
    logic [C_CH_W-1:0]   r_lock_ch, w_lock_nxt;
    logic [C_CH_W-1:0]   r_rr_ptr, w_rr_nxt;
    logic [C_CH_W-1:0]   w_grant, w_rx_tag;
    logic                w_grant_vld, w_load_ok, w_do_load, w_sel_ctrl;
    logic [0:C_DWIDTH-1] w_sel_data;
    logic [0:C_NUM_CH-1] w_read, w_write;
    logic                w_tag_ok, w_rx_ready;
    logic                r_tx_valid;
    logic [0:LW-1]       r_tx_data;
    logic [31:0]         r_tx_cnt, r_rx_cnt;
    logic [15:0]         r_rx_err;

    // Grant search: the lowest offset from rr_ptr wins, so the loop runs from the far end down.
    always_comb begin
        int idx;
        idx         = 0;
        w_grant     = '0;
        w_grant_vld = 1'b0;
        if (r_state == S_LOCKED) begin
            w_grant     = r_lock_ch;
            w_grant_vld = i_sfsl_exists[r_lock_ch];
        end else begin
            for (int i = C_NUM_CH - 1; i >= 0; i--) begin
                idx = int'(r_rr_ptr) + i;
                if (idx >= C_NUM_CH) idx = idx - C_NUM_CH;
                if (i_sfsl_exists[idx]) begin
                    w_grant     = C_CH_W'(idx);
                    w_grant_vld = 1'b1;
                end
            end
        end
    end

    assign w_sel_ctrl = i_sfsl_control[w_grant];
    assign w_sel_data = i_sfsl_data[int'(w_grant)*C_DWIDTH +: C_DWIDTH];
    assign w_load_ok  = !r_tx_valid | i_tx_ready;
    assign w_do_load  = i_rst_n & w_load_ok & w_grant_vld;
    assign w_rr_nxt   = (int'(w_grant) == C_NUM_CH - 1) ? '0 : w_grant + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_lock_nxt  = r_lock_ch;
        if (w_do_load && C_PKT_MODE != 0) begin
            if (w_sel_ctrl) begin
                w_state_nxt = S_IDLE;
            end else begin
                w_state_nxt = S_LOCKED;
                w_lock_nxt  = w_grant;
            end
        end
    end

    always_comb begin
        w_read = '0;
        if (w_do_load) w_read[w_grant] = 1'b1;
    end

    // RX steering is purely combinational; an out-of-range tag is swallowed.
    assign w_rx_tag = i_rx_data[0:C_CH_W-1];
    assign w_tag_ok = (int'(w_rx_tag) < C_NUM_CH);

    always_comb begin
        w_rx_ready = 1'b0;
        w_write    = '0;
        if (i_rst_n) begin
            w_rx_ready = w_tag_ok ? !i_mfsl_full[w_rx_tag] : 1'b1;
            if (w_tag_ok && i_rx_valid && w_rx_ready) w_write[w_rx_tag] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_lock_ch  <= '0;
            r_rr_ptr   <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_tx_cnt   <= '0;
            r_rx_cnt   <= '0;
            r_rx_err   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_lock_ch <= w_lock_nxt;
            if (w_do_load) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= {w_grant, w_sel_ctrl, w_sel_data};
                r_rr_ptr   <= w_rr_nxt;
            end else if (i_tx_ready) begin
                r_tx_valid <= 1'b0;
            end
            if (r_tx_valid && i_tx_ready) r_tx_cnt <= r_tx_cnt + 32'd1;
            if (|w_write) r_rx_cnt <= r_rx_cnt + 32'd1;
            if (i_rx_valid && !w_tag_ok && r_rx_err != 16'hFFFF) r_rx_err <= r_rx_err + 16'd1;
        end
    end

    assign o_sfsl_read    = w_read;
    assign o_tx_valid     = r_tx_valid;
    assign o_tx_data      = r_tx_data;
    assign o_rx_ready     = w_rx_ready;
    assign o_mfsl_write   = w_write;
    assign o_mfsl_data    = i_rx_data[C_CH_W+1:LW-1];
    assign o_mfsl_control = i_rx_data[C_CH_W];
    assign o_dbg_tx_cnt   = r_tx_cnt;
    assign o_dbg_rx_cnt   = r_rx_cnt;
    assign o_dbg_rx_err   = r_rx_err;
endmodule

// File: doc/m2_fsl_chan_mux.md
# m2_fsl_chan_mux

Parametrised multi-channel FSL multiplexer/demultiplexer between the user FSL endpoints and a single link word stream of the M2 serial interface. On transmit, it round-robin arbitrates C_NUM_CH slave FSL channels onto one tagged word stream, with optional packet locking. On receive, it steers tagged link words to C_NUM_CH master FSL channels, with per-channel backpressure, invalid-tag drop and debug counters. The core link interface stays single-channel; this block sits between it and the user FSL ports.

## Interface
Parameters:
- C_NUM_CH, 4: number of FSL channels, 2..8.
- C_DWIDTH, 64: FSL data width, 32 or 64.
- C_CH_W, 2: tag width, equal to ceil(log2(C_NUM_CH)), minimum 1.
- C_PKT_MODE, 1: 1 locks the grant until a control=1 word; 0 re-arbitrates every word.

Ports (all vectors big-endian [0:N-1]; channel k of a packed bus occupies bits [k*C_DWIDTH : (k+1)*C_DWIDTH-1]):
- i_clk  in  1  single clock; every register is in this domain.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_sfsl_data  in  C_NUM_CH*C_DWIDTH  slave FSL data, packed.
- i_sfsl_control  in  C_NUM_CH  slave FSL control bits.
- i_sfsl_exists  in  C_NUM_CH  slave FSL not-empty flags.
- o_sfsl_read  out  C_NUM_CH  slave FSL read strobes, at most one-hot.
- o_tx_valid  out  1  link TX word valid.
- o_tx_data  out  C_CH_W+1+C_DWIDTH  link TX word: [0:C_CH_W-1] tag, [C_CH_W] control, remainder data.
- i_tx_ready  in  1  link accepts the TX word.
- i_rx_valid  in  1  link RX word valid.
- i_rx_data  in  C_CH_W+1+C_DWIDTH  link RX word, same layout as o_tx_data.
- o_rx_ready  out  1  RX word consumed.
- o_mfsl_write  out  C_NUM_CH  master FSL write strobes.
- o_mfsl_data  out  C_DWIDTH  master FSL data, shared by all channels.
- o_mfsl_control  out  1  master FSL control bit, shared by all channels.
- i_mfsl_full  in  C_NUM_CH  master FSL full flags.
- o_dbg_tx_cnt  out  32  count of TX words sent.
- o_dbg_rx_cnt  out  32  count of RX words delivered.
- o_dbg_rx_err  out  16  count of RX words dropped for an invalid tag.

## Operation
TX path:
- One-entry output register holds the TX word. A transfer completes on o_tx_valid & i_tx_ready.
- load_ok = !o_tx_valid | i_tx_ready.
- State IDLE: the search starts at rr_ptr and wraps modulo C_NUM_CH. The first channel g with exists[g]=1 is granted. If load_ok, o_sfsl_read[g]=1 combinationally in the same cycle and the word is loaded with tag g.
- Every loaded word updates rr_ptr to (g+1) mod C_NUM_CH.
- If C_PKT_MODE=1 and the loaded word has control=0: go to LOCKED(g).
- LOCKED(g): only channel g may read. If exists[g]=0 mid-packet, the lock holds and no other channel is served. A loaded word with control=1 returns the state to IDLE.
- C_PKT_MODE=0: the block never leaves IDLE.
- o_sfsl_read is never asserted when !load_ok, and never for a channel with exists=0.

RX path (combinational, zero latency):
- ch = i_rx_data[0:C_CH_W-1].
- Valid tag (ch < C_NUM_CH): o_rx_ready = !i_mfsl_full[ch]. o_mfsl_write[ch] = i_rx_valid & o_rx_ready.
- Invalid tag (ch >= C_NUM_CH): o_rx_ready = 1, no write, the word is dropped and o_dbg_rx_err increments.
- o_mfsl_data and o_mfsl_control always present the RX payload.

Counters:
- o_dbg_tx_cnt increments on each TX transfer and wraps at 2^32.
- o_dbg_rx_cnt increments on each o_mfsl_write and wraps at 2^32.
- o_dbg_rx_err saturates at 0xFFFF.

Reset, with i_rst_n=0 sampled at a clock edge:
- o_tx_valid=0, o_tx_data=0, state=IDLE, rr_ptr=0, all counters=0.
- While i_rst_n=0: o_sfsl_read=0, o_mfsl_write=0, o_rx_ready=0.
- Reset mid-packet abandons the lock. No partial-packet recovery is attempted.

## Timing
- TX latency: o_sfsl_read in cycle n puts the word on o_tx_data with o_tx_valid=1 in cycle n+1.
- With i_tx_ready held at 1, throughput is one word per cycle with no bubbles.
- o_tx_data and o_tx_valid stay stable while o_tx_valid & !i_tx_ready.
- A simultaneous drain and load in the same cycle is legal and keeps full rate.
- RX: same-cycle handshake. Counters update at the edge after the event.

## Test plan
- C_NUM_CH=4, C_PKT_MODE=0, all exists=1, i_tx_ready=1: after reset, tags are 0,1,2,3,0,… with one word per cycle and o_dbg_tx_cnt=8 after 8 transfers.
- C_PKT_MODE=1: ch1 sends control 0,0,1 with exists[1]=0 for 3 cycles mid-packet while exists[2]=1 → the three ch1 words are contiguous and the ch2 word follows, tagged 2.
- Backpressure: hold i_tx_ready=0 for 5 cycles while a word is valid → o_tx_data is unchanged and o_sfsl_read=0 throughout; release → the next word arrives the following cycle.
- RX: word with tag 2 while i_mfsl_full[2]=1 → o_rx_ready=0 and no write. Clear full → o_mfsl_write=4'b0010 for one cycle and o_dbg_rx_cnt=1.
- C_NUM_CH=3, RX word with tag 3 → o_rx_ready=1, no write, o_dbg_rx_err=1.
- Reset asserted while LOCKED(1) with o_tx_valid=1 → next cycle o_tx_valid=0, counters=0, and the next grant goes to the lowest-numbered channel whose exists flag is set.
